data_demux4: RTL and testbench
==============================

Name: data_demux4

Overview:
- 1:4 registered demultiplexer: the distribution end of the 4:1 registered output selector already in the datapath.
- Takes one WIDTH-bit stream with a valid/ready handshake and steers each accepted word to one of four one-entry output slots.
- Each slot has its own valid/ready handshake.
- Destination comes from i_ctrl (direct mode) or an internal round-robin pointer (round-robin mode).

Parameters:
WIDTH, 16, data width of input and each output slot

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rst_n  input  1  synchronous, active-low reset
i_data  input  WIDTH  input word
i_ctrl  input  2  destination select in direct mode (0..3)
i_rr_mode  input  1  1 = round-robin destination, 0 = direct (i_ctrl)
i_valid  input  1  input word valid
o_ready  output  1  block can accept i_data this cycle
o_data_0..o_data_3  output  WIDTH each  slot k data
o_valid_0..o_valid_3  output  1 each  slot k holds a word
i_ready_0..i_ready_3  input  1 each  consumer k takes slot k word this cycle
o_rr_ptr  output  2  current round-robin pointer

Behaviour:
- Interface: one clock (i_clk); reset is synchronous and active-low (i_rst_n).
- Reset: sampled at posedge with i_rst_n=0. Sets all o_valid_k=0, o_data_k=0, o_rr_ptr=0. Reset has priority over every other event.
- Reset mid-operation: words held in slots are discarded, and any handshake in the same cycle is ignored.
- Destination: dest = i_rr_mode ? o_rr_ptr : i_ctrl. This is combinational on the current cycle's inputs.
- o_ready = !o_valid_dest || i_ready_dest.
  - The slot is ready when it is empty, or when it drains in the same cycle (pass-through).
  - This is a combinational path from i_ready_k and the select inputs to o_ready.
  - o_ready is driven regardless of i_valid.
- Accept = i_valid && o_ready. On accept:
  - o_data_dest <= i_data
  - o_valid_dest <= 1
  - Latency: word visible on slot one cycle after accept.
- Drain: o_valid_k && i_ready_k with no accept into slot k in the same cycle gives o_valid_k <= 0.
- Simultaneous drain and accept into the same slot: o_valid_k stays 1, o_data_k takes the new word. No bubble, no loss.
- Drains on other slots proceed independently in the same cycle. Any number of slots may drain per cycle.
- o_data_k holds its last written value while o_valid_k=0. It is never cleared except by reset.
- i_ready_k with o_valid_k=0 has no effect.
- Round-robin pointer:
  - Increments by 1 only on an accept while i_rr_mode=1.
  - Wraps 3 -> 0.
  - Unchanged in direct mode and unchanged on switching mode.
- Pointer stall: if the slot at o_rr_ptr is full and not draining, o_ready=0 and the pointer holds. The pointer never skips a full slot.
- i_valid=1 with o_ready=0: no state change. The source holds i_data/i_ctrl stable, but the block does not rely on it.
- Throughput: one word per cycle when consumers keep up.

Decomposition:
- Shared package:
  - NUM_OUT=4
  - default WIDTH=16
  - destination index type (2-bit)
  - mode encodings RR_MODE=1'b1, DIRECT_MODE=1'b0
- One natural sub-module, demux_slot: a one-entry register with load/drain/valid logic. It is instantiated 4 times.
- Top level holds the dest select, o_ready generation and the round-robin pointer.

Test Plan:
- Reset: hold i_rst_n=0 for 2 cycles with i_valid=1, i_data=16'hFFFF -> all o_valid_k=0, o_data_k=0, o_rr_ptr=0, and no capture.
- Direct steering: i_rr_mode=0, i_ready_k=0.
  - Send 16'h1111/ctrl=2, then 16'h2222/ctrl=0 -> next cycles o_valid_2=1, o_data_2=16'h1111; o_valid_0=1, o_data_0=16'h2222.
  - A further word with ctrl=2 sees o_ready=0 until i_ready_2=1.
- Pass-through: slot 1 full with 16'hAAAA, i_ready_1=1, i_valid=1, i_ctrl=1, i_data=16'hBBBB -> o_ready=1. Next cycle o_valid_1=1, o_data_1=16'hBBBB.
- Round-robin wrap: i_rr_mode=1, all i_ready_k=1, send 16'h0001..16'h0005 back-to-back.
  - Words land on slots 0,1,2,3,0.
  - o_rr_ptr sequence 0,1,2,3,0,1.
- RR stall: i_rr_mode=1, o_rr_ptr=2, slot 2 full, i_ready_2=0 -> o_ready=0, and o_rr_ptr stays 2 even though slot 3 is empty. Asserting i_ready_2 resumes acceptance.
- Reset mid-operation: slots 0 and 3 full, assert i_rst_n=0 for 1 cycle with an accept pending -> all valids 0, o_rr_ptr=0, and the pending word is not captured.

Source files
------------

// File: rtl/data_demux4_pkg.sv
// Shared types and constants for the 1:4 registered demultiplexer.
// Imported by the slot register and the top level.
package data_demux4_pkg;

  localparam int NUM_OUT = 4;
  localparam int WIDTH_DEF = 16;

  typedef logic [1:0] dest_t;

  localparam logic RR_MODE = 1'b1;
  localparam logic DIRECT_MODE = 1'b0;

endpackage

// File: rtl/data_demux4_slot.sv
// One-entry output slot: a load wins over a drain, so a word
// can be taken and replaced in the same cycle.
module data_demux4_slot
  import data_demux4_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= din;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/data_demux4.sv
// 1:4 registered demultiplexer with direct or round-robin
// steering into four one-entry handshaked slots.
module data_demux4
  import data_demux4_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic [1:0]       i_ctrl,
  input  logic             i_rr_mode,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_data_0,
  output logic [WIDTH-1:0] o_data_1,
  output logic [WIDTH-1:0] o_data_2,
  output logic [WIDTH-1:0] o_data_3,
  output logic             o_valid_0,
  output logic             o_valid_1,
  output logic             o_valid_2,
  output logic             o_valid_3,
  input  logic             i_ready_0,
  input  logic             i_ready_1,
  input  logic             i_ready_2,
  input  logic             i_ready_3,
  output logic [1:0]       o_rr_ptr
);

  dest_t              rr_ptr;
  dest_t              dest;
  logic               accept;
  logic [NUM_OUT-1:0] load;
  logic [NUM_OUT-1:0] valid;
  logic [NUM_OUT-1:0] ready;
  logic [WIDTH-1:0]   data [NUM_OUT];

  assign ready = {i_ready_3, i_ready_2, i_ready_1, i_ready_0};

  assign dest = (i_rr_mode == RR_MODE) ? rr_ptr : i_ctrl;

  // Pass-through: a full slot that drains this cycle can still load.
  assign o_ready = !valid[dest] || ready[dest];
  assign accept  = i_valid && o_ready;

  always_comb begin
    load = '0;
    if (accept) begin
      load[dest] = 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
    data_demux4_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk  (i_clk),
      .rst_n(i_rst_n),
      .load (load[k]),
      .din  (i_data),
      .ready(ready[k]),
      .data (data[k]),
      .valid(valid[k])
    );
  end

  // Pointer only moves on an accepted round-robin word; never skips.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rr_ptr <= '0;
    end else if (accept && i_rr_mode == RR_MODE) begin
      rr_ptr <= rr_ptr + 2'd1;
    end
  end

  assign o_rr_ptr  = rr_ptr;
  assign o_data_0  = data[0];
  assign o_data_1  = data[1];
  assign o_data_2  = data[2];
  assign o_data_3  = data[3];
  assign o_valid_0 = valid[0];
  assign o_valid_1 = valid[1];
  assign o_valid_2 = valid[2];
  assign o_valid_3 = valid[3];

endmodule

// File: tb/tb_data_demux4.sv
// Scoreboard bench for data_demux4: per-slot queues of expected
// words, plus a reference round-robin pointer.
module tb_data_demux4;

  logic        clk;
  logic        rst_n;
  logic [15:0] din;
  logic [1:0]  ctrl;
  logic        rr_mode;
  logic        vin;
  logic        rdy_out;
  logic [15:0] od [4];
  logic [3:0]  ov;
  logic [3:0]  rdy;
  logic [1:0]  ptr;

  int total = 0;
  int bad = 0;

  logic [15:0] sb [4][$];
  logic [15:0] mdata [4];
  logic [1:0]  mptr;

  data_demux4 #(.WIDTH(16)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_data   (din),
    .i_ctrl   (ctrl),
    .i_rr_mode(rr_mode),
    .i_valid  (vin),
    .o_ready  (rdy_out),
    .o_data_0 (od[0]),
    .o_data_1 (od[1]),
    .o_data_2 (od[2]),
    .o_data_3 (od[3]),
    .o_valid_0(ov[0]),
    .o_valid_1(ov[1]),
    .o_valid_2(ov[2]),
    .o_valid_3(ov[3]),
    .i_ready_0(rdy[0]),
    .i_ready_1(rdy[1]),
    .i_ready_2(rdy[2]),
    .i_ready_3(rdy[3]),
    .o_rr_ptr (ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_slots();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("valid%0d", k), {31'd0, ov[k]},
          {31'd0, sb[k].size() > 0});
      chk($sformatf("data%0d", k), {16'd0, od[k]},
          {16'd0, mdata[k]});
      if (sb[k].size() > 0)
        chk($sformatf("sbhead%0d", k), {16'd0, od[k]},
            {16'd0, sb[k][0]});
    end
    chk("rr_ptr", {30'd0, ptr}, {30'd0, mptr});
  endtask

  task automatic cyc(input logic rst, input logic v,
                     input logic [15:0] d, input logic [1:0] c,
                     input logic rr, input logic [3:0] r);
    logic [1:0] dst;
    logic       exp_rdy;
    rst_n = !rst;
    vin = v;
    din = d;
    ctrl = c;
    rr_mode = rr;
    rdy = r;
    #1;
    dst = rr ? mptr : c;
    exp_rdy = (sb[dst].size() == 0) || r[dst];
    if (!rst) chk("o_ready", {31'd0, rdy_out}, {31'd0, exp_rdy});
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        sb[k].delete();
        mdata[k] = '0;
      end
      mptr = '0;
    end else begin
      for (int k = 0; k < 4; k++)
        if (sb[k].size() > 0 && r[k]) void'(sb[k].pop_front());
      if (v && exp_rdy) begin
        sb[dst].push_back(d);
        mdata[dst] = d;
        if (rr) mptr = mptr + 2'd1;
      end
    end
    @(negedge clk);
    check_slots();
  endtask

  initial begin
    rst_n = 1'b0;
    vin = 1'b0;
    din = '0;
    ctrl = '0;
    rr_mode = 1'b0;
    rdy = '0;
    mptr = '0;
    for (int k = 0; k < 4; k++) mdata[k] = '0;

    // reset with a word offered
    cyc(1, 1, 16'hFFFF, 2'd1, 0, 4'h0);
    cyc(1, 1, 16'hFFFF, 2'd1, 0, 4'h0);
    chk("rst_v", {28'd0, ov}, 32'd0);

    // direct steering
    cyc(0, 1, 16'h1111, 2'd2, 0, 4'h0);
    cyc(0, 1, 16'h2222, 2'd0, 0, 4'h0);
    chk("dir_d2", {16'd0, od[2]}, 32'h1111);
    chk("dir_d0", {16'd0, od[0]}, 32'h2222);
    cyc(0, 1, 16'h3333, 2'd2, 0, 4'h0);
    chk("dir_blk", {16'd0, od[2]}, 32'h1111);
    cyc(0, 1, 16'h3333, 2'd2, 0, 4'h4);
    chk("dir_d2b", {16'd0, od[2]}, 32'h3333);
    cyc(0, 0, 16'h0000, 2'd0, 0, 4'hF);

    // pass-through on slot 1
    cyc(0, 1, 16'hAAAA, 2'd1, 0, 4'h0);
    cyc(0, 1, 16'hBBBB, 2'd1, 0, 4'h2);
    chk("pt_d1", {16'd0, od[1]}, 32'hBBBB);
    chk("pt_v1", {31'd0, ov[1]}, 32'd1);
    cyc(0, 0, 16'h0000, 2'd0, 0, 4'hF);

    // round-robin wrap
    for (int i = 1; i <= 5; i++)
      cyc(0, 1, 16'(i), 2'd3, 1, 4'hF);
    chk("rr_ptr_end", {30'd0, ptr}, 32'd1);
    chk("rr_wrap_d0", {16'd0, od[0]}, 32'h0005);
    cyc(0, 0, 16'h0000, 2'd0, 1, 4'hF);

    // round-robin stall on full slot 2
    cyc(0, 1, 16'h0A0A, 2'd2, 0, 4'h0);
    cyc(0, 1, 16'h0006, 2'd0, 1, 4'h0);
    cyc(0, 1, 16'h0007, 2'd0, 1, 4'h0);
    cyc(0, 1, 16'h0007, 2'd0, 1, 4'h0);
    chk("stall_ptr", {30'd0, ptr}, 32'd2);
    chk("stall_v3", {31'd0, ov[3]}, 32'd0);
    cyc(0, 1, 16'h0007, 2'd0, 1, 4'h4);
    chk("resume_d2", {16'd0, od[2]}, 32'h0007);
    cyc(0, 0, 16'h0000, 2'd0, 0, 4'hF);

    // reset mid-operation
    cyc(0, 1, 16'h5A5A, 2'd0, 0, 4'h0);
    cyc(0, 1, 16'hA5A5, 2'd3, 0, 4'h0);
    cyc(1, 1, 16'h5555, 2'd1, 0, 4'hF);
    chk("mid_v", {28'd0, ov}, 32'd0);
    chk("mid_d1", {16'd0, od[1]}, 32'd0);
    cyc(0, 0, 16'h0000, 2'd0, 0, 4'h0);

    // random mix
    for (int i = 0; i < 60; i++)
      cyc(0, 1'($urandom_range(0, 1)), 16'($urandom),
          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          4'($urandom_range(0, 15)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
